pio_write_sched: RTL and testbench
==================================

// Module: pio_write_sched
// PURPOSE
//   Avalon-MM master that shares the 12-bit output PIO slave between NUM_REQ requesters.
//   Round-robin arbitration; each grant becomes one zero-wait-state write to PIO address 0.
//   Sits between application logic (counters, FSMs) and the PIO slave in Lab3_sys.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8
//   DATA_W   12  PIO data width, equal to the PIO out_port width
// PORTS
//   clk              in   1              system clock, the same clock as the PIO slave
//   reset            in   1              synchronous, active-high reset
//   req              in   NUM_REQ        per-requester level request, held until ack
//   req_data         in   NUM_REQ*DATA_W packed values; requester i uses [i*DATA_W +: DATA_W]
//   ack              out  NUM_REQ        one-cycle pulse when requester i's write is done
//   busy             out  1              high in any state other than IDLE
//   last_value       out  DATA_W         value of the last completed write
//   avm_address      out  2              always 2'd0
//   avm_chipselect   out  1              Avalon chipselect to the PIO
//   avm_write_n      out  1              Avalon active-low write strobe
//   avm_writedata    out  32             {20'b0, data}
//   avm_readdata     in   32             PIO readdata; used only when PIO_READBACK_EN is defined
//   rb_error         out  1              sticky readback mismatch flag (macro builds only)
// BEHAVIOUR
//   - Reset values: ack=0, busy=0, last_value=0, avm_chipselect=0, avm_write_n=1,
//     avm_writedata=0, rb_error=0, RR pointer=0, state=IDLE.
//   - All outputs are registered; reset wins over every other event on the same edge.
//   - FSM states: IDLE, WRITE, [READBACK], DONE.
//     IDLE:     if |req, grant the first asserted index searching from ptr upward (mod NUM_REQ).
//               Latch grant index and its req_data; go to WRITE. Otherwise stay in IDLE.
//     WRITE:    avm_chipselect=1, avm_write_n=0, avm_writedata=latched data, for exactly 1 cycle.
//               The PIO has no waitrequest, so WRITE is never extended.
//               Next state is READBACK (macro builds) or DONE.
//     READBACK: avm_chipselect=1, avm_write_n=1. Sample avm_readdata[DATA_W-1:0] at the end of
//               the cycle; set rb_error if it differs from the latched data. Go to DONE.
//     DONE:     ack[grant]=1 for 1 cycle; last_value<=latched data; ptr<=(grant+1) mod NUM_REQ;
//               go to IDLE.
//   - Latency: req seen in IDLE at edge N; write strobe in cycle N+1; ack in cycle N+2
//     (N+3 with readback). Peak rate is 1 write per 3 cycles (4 with readback).
//   - Data is latched at grant. Changes to req_data after grant do not affect the write in progress.
//   - A req dropped before grant is ignored, with no ack. A req dropped after grant still gets
//     the write and the ack.
//   - A req still high in the IDLE cycle after its ack is treated as a new request.
//   - All requesters asserted: strict rotation 0,1,2,3,0,...; no requester waits more than
//     NUM_REQ grants.
//   - Reset mid-transaction: chipselect drops on the reset edge and no ack is issued.
//     The PIO keeps whatever value was already written.
//   - rb_error clears only on reset.
// CONFIGURATION
//   PIO_READBACK_EN defined:   READBACK state present; rb_error is live.
//   PIO_READBACK_EN undefined: WRITE goes straight to DONE; rb_error is tied 0;
//                              avm_readdata is unused.
// STRUCTURE
//   pio_sched_pkg: state enum (ST_IDLE, ST_WRITE, ST_READBACK, ST_DONE),
//                  PIO_DATA_ADDR=2'd0, PIO_DATA_W=12.
//   Sub-module pio_rr_arbiter: combinational one-hot grant from req and ptr; parameter NUM_REQ.
//   The FSM, data latch and Avalon drive live in the top level.
// TESTING
//   1 Reset held 3 cycles with req=4'hF: every output at its reset value; no chipselect.
//   2 Only req[2] high, data 12'hABC: one write with avm_writedata=32'h00000ABC in cycle N+1;
//     ack=4'b0100 in cycle N+2; last_value=12'hABC.
//   3 req=4'hF held, with data 12'h001/002/004/008: grant order 0,1,2,3,0; consecutive write
//     strobes 3 cycles apart.
//   4 After a grant to req[1], change req_data[1] to 12'hFFF: the write still carries the value
//     latched at grant.
//   5 Assert reset during WRITE: chipselect=0 on the next edge; no ack; ptr=0.
//   6 (PIO_READBACK_EN) Bench model returns 12'h123 after a write of 12'h124: rb_error=1 and
//     stays 1 after later matching writes.

Source files
------------

// File: rtl/pio_write_sched_pkg.sv
// Shared types and constants for the PIO write scheduler.
package pio_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READBACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
    localparam int         PIO_DATA_W    = 12;

endpackage

// File: rtl/pio_write_sched_if.sv
// Avalon-MM link between the write scheduler (master) and the PIO slave.
interface pio_write_sched_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/pio_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr.
module pio_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                                req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]  ptr,
    output logic [NUM_REQ-1:0]                                grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap the search index without a modulo operator.
            idx = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (idx >= (PTR_W + 1)'(NUM_REQ)) begin
                idx = idx - (PTR_W + 1)'(NUM_REQ);
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_write_sched.sv
// Round-robin Avalon-MM writer sharing one PIO output register between NUM_REQ requesters.
// Optional PIO_READBACK_EN adds a readback cycle and a sticky rb_error mismatch flag.
module pio_write_sched
    import pio_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = PIO_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [DATA_W-1:0]         last_value,
    pio_write_sched_if.master         avm,
    output logic                      rb_error,
    output state_t                    state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, next_state;
    logic [PTR_W-1:0]    ptr_q, grant_idx_q, sel_idx;
    logic [DATA_W-1:0]   data_q, sel_data;
    logic [NUM_REQ-1:0]  sel_grant, ack_d;
    logic                cs_d, wn_d, busy_d;
    logic [31:0]         wd_d;
    logic                cs_q, wn_q;
    logic [31:0]         wd_q;
    logic                unused_readdata;

    pio_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (sel_grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_grant[i]) sel_idx = PTR_W'(i);
        end
        sel_data = req_data[sel_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE:     if (|req) next_state = ST_WRITE;
`ifdef PIO_READBACK_EN
            ST_WRITE:    next_state = ST_READBACK;
`else
            ST_WRITE:    next_state = ST_DONE;
`endif
            ST_READBACK: next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered copies line up with the state.
    always_comb begin
        cs_d   = (next_state == ST_WRITE) || (next_state == ST_READBACK);
        wn_d   = (next_state != ST_WRITE);
        wd_d   = (next_state == ST_WRITE) ? {{(32-DATA_W){1'b0}}, sel_data} : 32'd0;
        ack_d  = (next_state == ST_DONE) ? (NUM_REQ'(1) << grant_idx_q) : '0;
        busy_d = (next_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            wd_q        <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            last_value  <= '0;
            ptr_q       <= '0;
            grant_idx_q <= '0;
            data_q      <= '0;
        end else begin
            cs_q <= cs_d;
            wn_q <= wn_d;
            wd_q <= wd_d;
            ack  <= ack_d;
            busy <= busy_d;
            if (state_q == ST_IDLE && |req) begin
                grant_idx_q <= sel_idx;
                data_q      <= sel_data;
            end
            if (next_state == ST_DONE) begin
                last_value <= data_q;
                ptr_q      <= (grant_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
            end
        end
    end

`ifdef PIO_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_error <= 1'b0;
        end else if (state_q == ST_READBACK && avm.avm_readdata[DATA_W-1:0] != data_q) begin
            rb_error <= 1'b1;
        end
    end
`else
    assign rb_error = 1'b0;
`endif

    assign unused_readdata    = ^avm.avm_readdata;
    assign avm.avm_address    = PIO_DATA_ADDR;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write_n    = wn_q;
    assign avm.avm_writedata  = wd_q;
    assign state              = state_q;

endmodule

// File: tb/tb_pio_write_sched.sv
// Self-checking bench for pio_write_sched with a simple PIO register model on the Avalon side.
module tb_pio_write_sched;
    import pio_sched_pkg::*;

    localparam int NR = 4;
    localparam int DW = 12;
`ifdef PIO_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  ack;
    logic           busy;
    logic [DW-1:0]  last_value;
    logic           rb_error;
    state_t         state;

    pio_write_sched_if bus();

    pio_write_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .busy       (busy),
        .last_value (last_value),
        .avm        (bus),
        .rb_error   (rb_error),
        .state      (state)
    );

    always #5 clk = ~clk;

    // PIO model: stores each write; 'corrupt' makes it read back a different value.
    logic [DW-1:0] pio_reg = '0;
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (bus.avm_chipselect && !bus.avm_write_n)
            pio_reg <= corrupt ? bus.avm_writedata[DW-1:0] - 12'd1 : bus.avm_writedata[DW-1:0];
    end
    assign bus.avm_readdata = {20'b0, pio_reg};

    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];

    task automatic test_reset();
        reset = 1'b1;
        req = 4'hF;
        req_data = {12'h008, 12'h004, 12'h002, 12'h001};
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.avm_chipselect !== 1'b0) begin
                bad++; $display("FAIL reset_cs: got %b want 0", bus.avm_chipselect);
            end
        end
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (last_value !== 12'h0) begin bad++; $display("FAIL reset_last: got %h want 000", last_value); end
        total++; if (bus.avm_write_n !== 1'b1) begin bad++; $display("FAIL reset_wn: got %b want 1", bus.avm_write_n); end
        total++; if (bus.avm_writedata !== 32'h0) begin bad++; $display("FAIL reset_wd: got %h want 0", bus.avm_writedata); end
        total++; if (rb_error !== 1'b0) begin bad++; $display("FAIL reset_rberr: got %b want 0", rb_error); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        @(negedge clk);
        reset = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        logic [DW-1:0] e;
        exp_q.delete();
        @(negedge clk);
        req_data[2*DW +: DW] = 12'hABC;
        req = 4'b0100;
        exp_q.push_back(12'hABC);
        @(negedge clk);
        total++;
        if (!(bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0)) begin
            bad++; $display("FAIL single_strobe: cs=%b wn=%b want cs=1 wn=0", bus.avm_chipselect, bus.avm_write_n);
        end else begin
            e = exp_q.pop_front();
            if (bus.avm_writedata !== {20'b0, e}) begin
                bad++; $display("FAIL single_data: got %h want %h", bus.avm_writedata, {20'b0, e});
            end
        end
        total++; if (bus.avm_address !== 2'd0) begin bad++; $display("FAIL single_addr: got %0d want 0", bus.avm_address); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        repeat (RB) @(negedge clk);
        @(negedge clk);
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b want 0100", ack); end
        total++; if (last_value !== 12'hABC) begin bad++; $display("FAIL single_last: got %h want abc", last_value); end
        req = '0;
        @(negedge clk);
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_rotation();
        logic [NR-1:0] aexp[5];
        logic [DW-1:0] e;
        int n, na, last;
        aexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n = 0; na = 0; last = 0;
        exp_q.delete();
        @(negedge clk); reset = 1'b1; req = '0;
        @(negedge clk); reset = 1'b0;
        req_data = {12'h008, 12'h004, 12'h002, 12'h001};
        req = 4'hF;
        exp_q.push_back(12'h001); exp_q.push_back(12'h002); exp_q.push_back(12'h004);
        exp_q.push_back(12'h008); exp_q.push_back(12'h001);
        for (int c = 0; c < 60 && (n < 5 || na < 5); c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                total++;
                if (na >= 5) begin
                    bad++; $display("FAIL rot_extra_ack: got %b want none", ack);
                end else if (ack !== aexp[na]) begin
                    bad++; $display("FAIL rot_ack%0d: got %b want %b", na, ack, aexp[na]);
                end
                na++;
            end
            if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rot_extra_write: got %h want none", bus.avm_writedata);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.avm_writedata !== {20'b0, e}) begin
                        bad++; $display("FAIL rot_data%0d: got %h want %h", n, bus.avm_writedata, {20'b0, e});
                    end
                end
                if (n > 0) begin
                    total++;
                    if (c - last != 3 + RB) begin
                        bad++; $display("FAIL rot_gap%0d: got %0d want %0d", n, c - last, 3 + RB);
                    end
                end
                last = c;
                n++;
                if (n == 5) req = '0;
            end
        end
        total++; if (n != 5 || na != 5) begin bad++; $display("FAIL rot_timeout: writes=%0d acks=%0d want 5/5", n, na); end
        @(negedge clk);
    endtask

    task automatic test_latch();
        logic [DW-1:0] e;
        bit seen;
        exp_q.delete();
        req_data[1*DW +: DW] = 12'h5A5;
        req = 4'b0010;
        exp_q.push_back(12'h5A5);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                total++;
                if (bus.avm_writedata !== {20'b0, e}) begin
                    bad++; $display("FAIL latch_data: got %h want %h", bus.avm_writedata, {20'b0, e});
                end
                req_data[1*DW +: DW] = 12'hFFF;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL latch_write_timeout: got none want write"); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                seen = 1'b1;
                total++; if (ack !== 4'b0010) begin bad++; $display("FAIL latch_ack: got %b want 0010", ack); end
                total++; if (last_value !== 12'h5A5) begin bad++; $display("FAIL latch_last: got %h want 5a5", last_value); end
                req = '0;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL latch_ack_timeout: got none want 0010"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        bit seen;
        exp_q.delete();
        req_data[3*DW +: DW] = 12'h777;
        req = 4'b1000;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0) begin
                seen = 1'b1;
                reset = 1'b1;
                req = '0;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_write_timeout: got none want write"); end
        @(negedge clk);
        total++; if (bus.avm_chipselect !== 1'b0) begin bad++; $display("FAIL mid_cs: got %b want 0", bus.avm_chipselect); end
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL mid_ack: got %b want 0000", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL mid_ack2: got %b want 0000", ack); end
        // Pointer must be back at 0: with every request up, requester 0 wins first.
        req_data = {12'h444, 12'h333, 12'h222, 12'h111};
        req = 4'hF;
        exp_q.push_back(12'h111);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                total++;
                if (bus.avm_writedata !== {20'b0, e}) begin
                    bad++; $display("FAIL mid_ptr_data: got %h want %h", bus.avm_writedata, {20'b0, e});
                end
                req = '0;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_ptr_timeout: got none want write"); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                seen = 1'b1;
                total++; if (ack !== 4'b0001) begin bad++; $display("FAIL mid_ptr_ack: got %b want 0001", ack); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_ptr_ack_timeout: got none want 0001"); end
        @(negedge clk);
    endtask

`ifdef PIO_READBACK_EN
    task automatic test_readback();
        bit seen;
        total++; if (rb_error !== 1'b0) begin bad++; $display("FAIL rb_clean: got %b want 0", rb_error); end
        corrupt = 1'b1;
        req_data[1*DW +: DW] = 12'h124;
        req = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                seen = 1'b1;
                req = '0;
                total++; if (pio_reg !== 12'h123) begin bad++; $display("FAIL rb_model: got %h want 123", pio_reg); end
                total++; if (rb_error !== 1'b1) begin bad++; $display("FAIL rb_set: got %b want 1", rb_error); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rb_ack_timeout: got none want ack"); end
        @(negedge clk);
        corrupt = 1'b0;
        req_data[2*DW +: DW] = 12'h456;
        req = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                seen = 1'b1;
                req = '0;
                total++; if (rb_error !== 1'b1) begin bad++; $display("FAIL rb_sticky: got %b want 1", rb_error); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rb_ack2_timeout: got none want ack"); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_latch();
        test_reset_mid();
`ifdef PIO_READBACK_EN
        test_readback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
